mult_acc_pipe: RTL and testbench
================================

MULT_ACC_PIPE -- requirements
Module: mult_acc_pipe

Interface
REQ-001 Parameter A_W, default 8, operand a width in bits.
REQ-002 Parameter B_W, default 8, operand b width in bits.
REQ-003 Parameter STAGES, default 4, total pipeline depth; legal range 2..8.
REQ-004 Parameter ACC_W, default 32, result width; ACC_W >= A_W+B_W.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  input beat offered.
REQ-008 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-009 a  in  A_W  multiplicand.
REQ-010 b  in  B_W  multiplier.
REQ-011 signed_mode  in  1  1 = a, b two's complement; 0 = unsigned; sampled per beat.
REQ-012 acc_en  in  1  1 = beat joins running accumulation; 0 = pass-through product; sampled per beat.
REQ-013 in_last  in  1  with acc_en=1, closes accumulation group; ignored when acc_en=0.
REQ-014 out_valid  out  1  result beat available.
REQ-015 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-016 result  out  ACC_W  product or accumulated sum.
REQ-017 ovf  out  1  saturation occurred in the group producing this result.

Function
REQ-018 Product = a*b at full A_W+B_W width, signed or unsigned per signed_mode, sign/zero-extended to ACC_W.
REQ-019 Stages 1..STAGES-1 carry product, valid, acc_en, in_last, signed_mode; stage STAGES is the accumulator/output register.
REQ-020 Unstalled latency: accepted beat at edge N appears on result at edge N+STAGES (pass-through beat or closing in_last beat).
REQ-021 Global stall: in_ready = !out_valid || out_ready; when in_ready=0 every stage and the accumulator hold.
REQ-022 Bubbles (in_valid=0 when accepted) propagate as invalid stages; they never modify the accumulator.
REQ-023 acc_en=0 beat: out_valid=1 with result = extended product, ovf=0; running sum untouched.
REQ-024 acc_en=1, in_last=0 beat: sum += product with saturation; out_valid not asserted for it.
REQ-025 acc_en=1, in_last=1 beat: result = saturated(sum+product), ovf = group sticky flag, out_valid=1; sum and sticky flag clear to 0 in the same cycle.
REQ-026 Saturation: signed group clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned clamps to 2^ACC_W-1; any clamp sets sticky flag.
REQ-027 Group mode is the signed_mode of its first beat; later beats' signed_mode in the same group are ignored.
REQ-028 Interleaved acc_en=0 beat inside an open group outputs its product and leaves the open sum intact.
REQ-029 out_valid, result, ovf stay stable while out_valid && !out_ready.

Reset
REQ-030 reset_n low asynchronously clears all stage valids, sum, sticky flag; out_valid=0, result=0, ovf=0, in_ready=1 while low.
REQ-031 Reset mid-group discards the partial sum; first beat after release starts a new group.
REQ-032 No output beat from before reset is emitted after release.

Structure
REQ-033 Package mult_pkg holds default A_W/B_W/STAGES/ACC_W constants and the saturating-add function.
REQ-034 One sub-module mult_pipe_stage (parametrised-width register with valid and enable), instantiated STAGES-1 times via generate.

Verification
REQ-035 Unsigned pass-through, STAGES=4: a=255,b=255,acc_en=0 at edge 0 -> result=65025, out_valid at edge 4, ovf=0.
REQ-036 Signed: a=-128,b=127,signed_mode=1 -> result=-16256 sign-extended to 32 bits.
REQ-037 Group of 4 beats a=3,b=5, last on beat 4 -> one out_valid, result=60, three silent beats.
REQ-038 ACC_W=16 unsigned group 2 x (255*255) -> result=65535, ovf=1; next group 1*1 -> result=1, ovf=0.
REQ-039 out_ready=0 for 3 cycles with full pipe -> in_ready=0, result held, no beat lost or duplicated; order preserved.
REQ-040 reset_n pulsed low after 2 beats of open group -> outputs 0 immediately; post-release group 2*2 last -> result=4.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared defaults and the saturating adder for the multiply-accumulate pipeline.
package mult_pkg;

  localparam int DEF_A_W    = 8;
  localparam int DEF_B_W    = 8;
  localparam int DEF_STAGES = 4;
  localparam int DEF_ACC_W  = 32;

  typedef struct packed {
    logic [63:0] val;
    logic        clamp;
  } sat_t;

  // x, y arrive already extended to 64 bits; the sum is clamped to a w-bit range.
  function automatic sat_t sat_add(input logic [63:0] x, input logic [63:0] y,
                                   input logic sgn, input int w);
    logic signed [65:0] s, hi, lo;
    sat_t r;
    if (sgn) begin
      s  = $signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y});
      hi = (66'sd1 <<< (w - 1)) - 66'sd1;
      lo = -(66'sd1 <<< (w - 1));
    end else begin
      s  = $signed({2'b00, x}) + $signed({2'b00, y});
      hi = (66'sd1 <<< w) - 66'sd1;
      lo = '0;
    end
    r.clamp = (s > hi) || (s < lo);
    if (s > hi)      r.val = hi[63:0];
    else if (s < lo) r.val = lo[63:0];
    else             r.val = s[63:0];
    return r;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One pipeline register with valid bit; holds its contents while en is low.
module mult_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         vld_i,
  input  logic [W-1:0] d_i,
  output logic         vld_o,
  output logic [W-1:0] q_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d = vld_i;
      dat_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = dat_q;

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined multiplier with optional saturating accumulation groups and a
// single global stall driven by the output handshake.
module mult_acc_pipe
  import mult_pkg::*;
#(
  parameter int A_W    = DEF_A_W,
  parameter int B_W    = DEF_B_W,
  parameter int STAGES = DEF_STAGES,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  input  logic             signed_mode,
  input  logic             acc_en,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             ovf
);

  localparam int P_W = A_W + B_W;
  localparam int D_W = P_W + 3;
  localparam int NS  = STAGES - 1;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sticky_q, sticky_d;
  logic             grp_open_q, grp_open_d;
  logic             grp_sgn_q, grp_sgn_d;

  logic                  en, eff_sgn;
  logic signed [P_W-1:0] prod_s;
  logic        [P_W-1:0] prod_u, prod_in;
  logic [NS:0]           vld_pipe;
  logic [NS:0][D_W-1:0]  dat_pipe;

  assign in_ready = !out_valid_q || out_ready;
  assign en       = in_ready;

  // Group mode is latched at the input from the first beat, so every product of
  // a group is formed in the group's arithmetic regardless of later signed_mode.
  assign eff_sgn = (acc_en && grp_open_q) ? grp_sgn_q : signed_mode;
  assign prod_s  = $signed({{B_W{a[A_W-1]}}, a}) * $signed({{A_W{b[B_W-1]}}, b});
  assign prod_u  = {{B_W{1'b0}}, a} * {{A_W{1'b0}}, b};
  assign prod_in = eff_sgn ? prod_s : prod_u;

  always_comb begin
    grp_open_d = grp_open_q;
    grp_sgn_d  = grp_sgn_q;
    if (in_valid && en && acc_en) begin
      grp_open_d = !in_last;
      grp_sgn_d  = eff_sgn;
    end
  end

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = {prod_in, acc_en, in_last, eff_sgn};

  for (genvar i = 0; i < NS; i++) begin : g_stage
    mult_pipe_stage #(.W(D_W)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en),
      .vld_i   (vld_pipe[i]),
      .d_i     (dat_pipe[i]),
      .vld_o   (vld_pipe[i+1]),
      .q_o     (dat_pipe[i+1])
    );
  end

  logic [P_W-1:0]   prod_t;
  logic             acc_t, last_t, sgn_t;
  logic [ACC_W-1:0] prod_ext;
  logic [63:0]      sum_x, prod_x;
  sat_t             sat_r;
  logic             unused_sat;

  assign {prod_t, acc_t, last_t, sgn_t} = dat_pipe[NS];

  always_comb begin
    if (sgn_t) begin
      prod_ext = ACC_W'($signed(prod_t));
      prod_x   = 64'($signed(prod_ext));
      sum_x    = 64'($signed(sum_q));
    end else begin
      prod_ext = ACC_W'(prod_t);
      prod_x   = 64'(prod_ext);
      sum_x    = 64'(sum_q);
    end
  end

  assign sat_r      = sat_add(sum_x, prod_x, sgn_t, ACC_W);
  assign unused_sat = ^sat_r.val;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    sum_d       = sum_q;
    sticky_d    = sticky_q;
    if (en) begin
      out_valid_d = 1'b0;
      if (vld_pipe[NS]) begin
        if (!acc_t) begin
          out_valid_d = 1'b1;
          result_d    = prod_ext;
          ovf_d       = 1'b0;
        end else if (!last_t) begin
          sum_d    = sat_r.val[ACC_W-1:0];
          sticky_d = sticky_q | sat_r.clamp;
        end else begin
          out_valid_d = 1'b1;
          result_d    = sat_r.val[ACC_W-1:0];
          ovf_d       = sticky_q | sat_r.clamp;
          sum_d       = '0;
          sticky_d    = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      sum_q       <= '0;
      sticky_q    <= 1'b0;
      grp_open_q  <= 1'b0;
      grp_sgn_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      sum_q       <= sum_d;
      sticky_q    <= sticky_d;
      grp_open_q  <= grp_open_d;
      grp_sgn_q   <= grp_sgn_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Scoreboard bench: a 32-bit and a 16-bit accumulator instance run in lockstep
// on the same stimulus, each checked against an arithmetic reference model.
module tb_mult_acc_pipe;
  localparam int STAGES = 4;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, signed_mode, acc_en, in_last;
  logic [7:0]  a, b;
  logic        ir0, ov0, ovf0, ir1, ov1, ovf1;
  logic [31:0] res0;
  logic [15:0] res1;

  always #5 clk = ~clk;

  mult_acc_pipe #(.A_W(8), .B_W(8), .STAGES(STAGES), .ACC_W(32)) dut0 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir0),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .in_last(in_last),
    .out_valid(ov0), .out_ready(out_ready), .result(res0), .ovf(ovf0));

  mult_acc_pipe #(.A_W(8), .B_W(8), .STAGES(STAGES), .ACC_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .in_last(in_last),
    .out_valid(ov1), .out_ready(out_ready), .result(res1), .ovf(ovf1));

  typedef struct { longint v; bit o; } exp_t;
  exp_t   q0[$], q1[$];
  int     total = 0, bad = 0;
  int     rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  longint m_sum[2];
  bit     m_st[2];
  bit     m_open, m_mode;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic longint sat(longint s, bit sg, int w, output bit c);
    longint hi, lo;
    hi = sg ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = sg ? -(longint'(1) << (w - 1)) : 0;
    c  = (s > hi) || (s < lo);
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction

  task automatic model_clear();
    q0.delete(); q1.delete();
    m_open = 0; m_mode = 0;
    for (int k = 0; k < 2; k++) begin m_sum[k] = 0; m_st[k] = 0; end
  endtask

  task automatic model_beat(logic [7:0] a_, logic [7:0] b_, logic sm, logic ae, logic last);
    longint p, s;
    bit md, c;
    exp_t e;
    md = (ae && m_open) ? m_mode : sm;
    p  = md ? longint'($signed(a_)) * longint'($signed(b_)) : longint'(a_) * longint'(b_);
    if (!ae) begin
      e.v = p; e.o = 0;
      q0.push_back(e); q1.push_back(e);
    end else begin
      if (!m_open) begin m_open = 1; m_mode = sm; end
      for (int k = 0; k < 2; k++) begin
        s = sat(m_sum[k] + p, md, (k == 0) ? 32 : 16, c);
        m_st[k] |= c;
        if (last) begin
          e.v = s; e.o = m_st[k];
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          m_sum[k] = 0; m_st[k] = 0;
        end else m_sum[k] = s;
      end
      if (last) m_open = 0;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that takes the beat.
  task automatic send(logic v, logic [7:0] a_, logic [7:0] b_, logic sm, logic ae, logic last);
    int n;
    n = 0;
    in_valid = v; a = a_; b = b_; signed_mode = sm; acc_en = ae; in_last = last;
    @(negedge clk);
    while (!ir0 && n < 200) begin @(negedge clk); n++; end
    if (!ir0) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b want 1", ir0);
    end else if (v) model_beat(a_, b_, sm, ae, last);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_clear();
    #1;
    chk("rst_valid0", {63'd0, ov0}, 64'd0);
    chk("rst_res0",   {31'd0, ovf0, res0}, 64'd0);
    chk("rst_res1",   {47'd0, ovf1, ov1, res1}, 64'd0);
    chk("rst_ready",  {62'd0, ir0, ir1}, 64'd3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      out_ready = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on every handshake and checks outputs are held during stalls.
  logic        hold0 = 0, hold1 = 0;
  logic [32:0] hv0;
  logic [16:0] hv1;
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      hold0 = 0; hold1 = 0;
    end else begin
      if (hold0) chk("hold0", {30'd0, ov0, ovf0, res0}, {30'd0, 1'b1, hv0});
      if (hold1) chk("hold1", {46'd0, ov1, ovf1, res1}, {46'd0, 1'b1, hv1});
      if (ov0 && out_ready) begin
        if (q0.size() == 0) chk("extra0", {31'd0, ovf0, res0}, 64'hDEAD);
        else begin e = q0.pop_front(); chk("out0", {31'd0, ovf0, res0}, {31'd0, e.o, e.v[31:0]}); end
      end
      if (ov1 && out_ready) begin
        if (q1.size() == 0) chk("extra1", {47'd0, ovf1, res1}, 64'hDEAD);
        else begin e = q1.pop_front(); chk("out1", {47'd0, ovf1, res1}, {47'd0, e.o, e.v[15:0]}); end
      end
      hold0 = ov0 && !out_ready; hv0 = {ovf0, res0};
      hold1 = ov1 && !out_ready; hv1 = {ovf1, res1};
    end
  end

  initial begin
    int n;
    reset_n = 1; in_valid = 0; a = 0; b = 0; signed_mode = 0; acc_en = 0; in_last = 0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Unsigned pass-through latency: visible exactly STAGES edges after driving.
    in_valid = 1; a = 8'd255; b = 8'd255; signed_mode = 0; acc_en = 0; in_last = 0;
    chk("lat_ready", {63'd0, ir0}, 64'd1);
    model_beat(8'd255, 8'd255, 0, 0, 0);
    for (int k = 1; k <= STAGES; k++) begin
      @(posedge clk); #1;
      in_valid = 0;
      chk($sformatf("lat_edge%0d", k), {63'd0, ov0}, {63'd0, (k == STAGES)});
    end

    send(1, 8'h80, 8'd127, 1, 0, 0);                      // -16256
    for (int k = 0; k < 4; k++) send(1, 8'd3, 8'd5, 0, 1, k == 3);   // 60
    send(1, 8'd255, 8'd255, 0, 1, 0);                     // 16-bit saturates
    send(1, 8'd255, 8'd255, 0, 1, 1);
    send(1, 8'd1, 8'd1, 0, 1, 1);                         // fresh group, ovf clear
    for (int k = 0; k < 3; k++) send(1, 8'h80, 8'h80, 1, 1, k == 2); // +clamp on 16-bit
    for (int k = 0; k < 3; k++) send(1, 8'h80, 8'd127, 1, 1, k == 2); // -clamp on 16-bit
    send(1, 8'd6, 8'd7, 0, 1, 0);                         // open group ...
    send(1, 8'd9, 8'd9, 0, 0, 0);                         // ... interleaved pass-through
    send(1, 8'd2, 8'd3, 1, 1, 1);                         // mode ignored, closes 42+6
    repeat (STAGES + 2) @(posedge clk); #1;

    // Full-pipe stall: downstream blocks for several cycles.
    rdy_mode = 2;
    @(posedge clk); #1;
    for (int k = 0; k < STAGES; k++) send(1, 8'(k + 10), 8'd11, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall_ready", {62'd0, ir0, ov0}, 64'd1);
    end
    rdy_mode = 1;
    repeat (STAGES + 3) @(posedge clk); #1;

    // Reset while a group is open and a pass-through is in flight.
    send(1, 8'd7, 8'd9, 0, 1, 0);
    send(1, 8'd7, 8'd9, 0, 1, 0);
    send(1, 8'd5, 8'd5, 0, 0, 0);
    do_reset();
    send(1, 8'd2, 8'd2, 0, 1, 1);                         // 4
    repeat (STAGES + 2) @(posedge clk); #1;

    // Randomised traffic with bubbles, groups and random backpressure.
    rdy_mode = 0;
    for (int k = 0; k < 400; k++)
      send(($urandom_range(0, 4) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0));

    rdy_mode = 1;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
